// File: rtl/sc_io_bank_pkg.sv
// Shared constants, register-decode enum and slice helper for the memory-mapped I/O bank.
package sc_io_pkg;

    localparam int unsigned IN_BASE         = 0;
    localparam int unsigned OUT_BASE        = 8;
    localparam int unsigned CHG_IDX         = 16;
    localparam int unsigned MASK_IDX        = 17;
    localparam int unsigned IO_WINDOW_BYTES = 128;
    localparam int unsigned MAX_CH          = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_IN,
        REG_OUT,
        REG_CHG,
        REG_MASK
    } reg_kind_t;

    // Pulls channel idx out of a packed bus of width-bit channels, zero-extended to 32 bits.
    function automatic logic [31:0] chan_slice(input logic [MAX_CH*32-1:0] vec,
                                               input int unsigned idx,
                                               input int unsigned width);
        logic [31:0] keep;
        keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return 32'(vec >> (idx * width)) & keep;
    endfunction

endpackage

// File: rtl/sc_io_bank_if.sv
// CPU load/store bus as seen by the I/O bank.
interface sc_io_bank_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        io_sel;

    modport master (output addr, output wdata, output we, input rdata, input io_sel);
    modport slave  (input addr, input wdata, input we, output rdata, output io_sel);

endinterface

// File: rtl/sc_io_bank_sync_edge.sv
// Two-flop synchroniser plus history register for one input channel; flags any change.
module sc_io_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] synced,
    output logic             change
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;
    logic [WIDTH-1:0] history;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stage1  <= '0;
            stage2  <= '0;
            history <= '0;
        end else begin
            stage1  <= pin;
            stage2  <= stage1;
            history <= stage2;
        end
    end

    assign synced = stage2;
    assign change = (stage2 != history);

endmodule

// File: rtl/sc_io_bank.sv
// Parametrised memory-mapped I/O bank: synchronised inputs, registered outputs,
// sticky change flags with write-1-to-clear, interrupt mask and irq.
module sc_io_bank
    import sc_io_pkg::*;
#(
    parameter int          N_IN      = 2,
    parameter int          N_OUT     = 2,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] IO_BASE   = 32'h0000_0080,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                   clock,
    input  logic                   resetn,
    sc_io_bank_if.slave            bus,
    input  logic [N_IN*WIDTH-1:0]  in_ports,
    output logic [N_OUT*WIDTH-1:0] out_ports,
    output logic                   irq
);

    logic [N_IN*WIDTH-1:0]  sync_bus;
    logic [N_IN-1:0]        pulse;
    logic [N_OUT*WIDTH-1:0] out_reg;
    logic [N_IN-1:0]        chg;
    logic [N_IN-1:0]        mask;
    logic [N_IN-1:0]        chg_next;
    logic [N_IN-1:0]        mask_next;
    logic [N_IN-1:0]        clr;
    logic [N_IN-1:0]        set;
    logic [1:0]             settle;
    logic [31:0]            widx;
    logic [31:0]            in_ch;
    logic [31:0]            out_ch;
    logic [31:0]            rd;
    logic [MAX_CH*32-1:0]   sync_ext;
    logic [MAX_CH*32-1:0]   out_ext;
    reg_kind_t              kind;
    logic                   unused_bits;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        sc_io_sync_edge #(.WIDTH(WIDTH)) u_sync (
            .clock  (clock),
            .resetn (resetn),
            .pin    (in_ports[k*WIDTH +: WIDTH]),
            .synced (sync_bus[k*WIDTH +: WIDTH]),
            .change (pulse[k])
        );
    end

    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign bus.io_sel = ((bus.addr - IO_BASE) < IO_WINDOW_BYTES);
    assign widx       = {27'd0, bus.addr[6:2]};
    assign in_ch      = widx - IN_BASE;
    assign out_ch     = widx - OUT_BASE;

    always_comb begin
        kind = REG_NONE;
        if (bus.io_sel) begin
            if (widx < OUT_BASE) begin
                if (in_ch < N_IN) kind = REG_IN;
            end else if (widx < OUT_BASE + MAX_CH) begin
                if (out_ch < N_OUT) kind = REG_OUT;
            end else if (widx == CHG_IDX) begin
                kind = REG_CHG;
            end else if (widx == MASK_IDX) begin
                kind = REG_MASK;
            end
        end
    end

    always_comb begin
        sync_ext = '0;
        out_ext  = '0;
        sync_ext[N_IN*WIDTH-1:0]  = sync_bus;
        out_ext[N_OUT*WIDTH-1:0]  = out_reg;
        rd = '0;
        unique case (kind)
            REG_IN:   rd = chan_slice(sync_ext, in_ch, WIDTH);
            REG_OUT:  rd = chan_slice(out_ext, out_ch, WIDTH);
            REG_CHG:  rd[N_IN-1:0] = chg;
            REG_MASK: rd[N_IN-1:0] = mask;
            default:  rd = '0;
        endcase
        bus.rdata = resetn ? rd : 32'd0;
    end

    // A fresh change beats a simultaneous software clear; changes are ignored until the settle counter saturates.
    always_comb begin
        clr       = (bus.we && kind == REG_CHG) ? bus.wdata[N_IN-1:0] : '0;
        set       = (settle == 2'd3) ? pulse : '0;
        chg_next  = (chg & ~clr) | set;
        mask_next = (bus.we && kind == REG_MASK) ? bus.wdata[N_IN-1:0] : mask;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            settle  <= 2'd0;
            chg     <= '0;
            mask    <= '0;
            irq     <= 1'b0;
            out_reg <= {N_OUT{OUT_RESET}};
        end else begin
            if (settle != 2'd3) settle <= settle + 2'd1;
            chg  <= chg_next;
            mask <= mask_next;
            irq  <= |(chg_next & mask_next);
            for (int k = 0; k < N_OUT; k++) begin
                if (bus.we && kind == REG_OUT && out_ch == k)
                    out_reg[k*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
            end
        end
    end

    assign out_ports = out_reg;

endmodule

// File: tb/tb_sc_io_bank.sv
// Self-checking bench for sc_io_bank: default 2x32-bit instance plus a narrow 8-bit instance.
module tb_sc_io_bank;

    logic        clock = 1'b0;
    logic        resetn_a;
    logic        resetn_b;
    logic [63:0] in_a;
    logic [63:0] out_a;
    logic        irq_a;
    logic [15:0] in_b;
    logic [15:0] out_b;
    logic        irq_b;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_sel;
        logic [63:0] exp_out;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb_q[$];

    sc_io_bank_if bus_a ();
    sc_io_bank_if bus_b ();

    sc_io_bank dut_a (
        .clock     (clock),
        .resetn    (resetn_a),
        .bus       (bus_a),
        .in_ports  (in_a),
        .out_ports (out_a),
        .irq       (irq_a)
    );

    sc_io_bank #(.WIDTH(8), .OUT_RESET(8'hA5)) dut_b (
        .clock     (clock),
        .resetn    (resetn_b),
        .bus       (bus_b),
        .in_ports  (in_b),
        .out_ports (out_b),
        .irq       (irq_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_sel, input logic [63:0] exp_out);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_sel = exp_sel; v.exp_out = exp_out;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata;
        #1;
    endtask

    task automatic drive_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wdata;
        #1;
    endtask

    task automatic read_a(input logic [31:0] addr, input logic [31:0] exp, input string name);
        drive_a(1'b0, addr, 32'd0);
        check_output(name, {32'd0, bus_a.rdata}, {32'd0, exp});
    endtask

    task automatic read_b(input logic [31:0] addr, input logic [31:0] exp, input string name);
        drive_b(1'b0, addr, 32'd0);
        check_output(name, {32'd0, bus_b.rdata}, {32'd0, exp});
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] wdata);
        drive_a(1'b1, addr, wdata);
        tick();
        drive_a(1'b0, addr, 32'd0);
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] wdata);
        drive_b(1'b1, addr, wdata);
        tick();
        drive_b(1'b0, addr, 32'd0);
    endtask

    // Drives one table vector, checks the same-cycle read and queues the post-edge output expectation.
    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [63:0] exp;
        drive_a(v.we, v.addr, v.wdata);
        check_output($sformatf("vec%0d_rdata", idx), {32'd0, bus_a.rdata}, {32'd0, v.exp_rdata});
        check_output($sformatf("vec%0d_io_sel", idx), {63'd0, bus_a.io_sel}, {63'd0, v.exp_sel});
        sb_q.push_back(v.exp_out);
        tick();
        exp = sb_q.pop_front();
        check_output($sformatf("vec%0d_out_ports", idx), out_a, exp);
    endtask

    initial begin
        logic [63:0] o1;
        logic [63:0] o2;
        o1 = {32'hDEAD_BEEF, 32'h0};
        o2 = {32'hDEAD_BEEF, 32'h0000_1111};

        vecs.push_back(mk(1'b0, 32'h0000_00A4, 32'h0,         32'h0,         1'b1, 64'h0));
        vecs.push_back(mk(1'b1, 32'h0000_00A4, 32'hDEAD_BEEF, 32'h0,         1'b1, o1));
        vecs.push_back(mk(1'b0, 32'h0000_00A4, 32'h0,         32'hDEAD_BEEF, 1'b1, o1));
        vecs.push_back(mk(1'b1, 32'h0000_00A8, 32'h1234_5678, 32'h0,         1'b1, o1));
        vecs.push_back(mk(1'b0, 32'h0000_00A8, 32'h0,         32'h0,         1'b1, o1));
        vecs.push_back(mk(1'b1, 32'h0000_00A0, 32'h0000_1111, 32'h0,         1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_00A0, 32'h0,         32'h0000_1111, 1'b1, o2));
        vecs.push_back(mk(1'b1, 32'h0000_0120, 32'hFFFF_FFFF, 32'h0,         1'b0, o2));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 32'h0000_AAAA, 32'h0,         1'b0, o2));
        vecs.push_back(mk(1'b1, 32'h8000_00A0, 32'h0000_BBBB, 32'h0,         1'b0, o2));
        vecs.push_back(mk(1'b0, 32'h0000_0080, 32'h0,         32'h0000_0001, 1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_0087, 32'h0,         32'h0000_00C3, 1'b1, o2));
        vecs.push_back(mk(1'b1, 32'h0000_0084, 32'h0000_FFFF, 32'h0000_00C3, 1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_0088, 32'h0,         32'h0,         1'b1, o2));
        vecs.push_back(mk(1'b1, 32'h0000_00C8, 32'hFFFF_FFFF, 32'h0,         1'b1, o2));
        vecs.push_back(mk(1'b1, 32'h0000_00C4, 32'hFFFF_FFFF, 32'h0,         1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_00C4, 32'h0,         32'h0000_0003, 1'b1, o2));
        vecs.push_back(mk(1'b1, 32'h0000_00C4, 32'h0,         32'h0000_0003, 1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_00C4, 32'h0,         32'h0,         1'b1, o2));
        vecs.push_back(mk(1'b0, 32'h0000_00C0, 32'h0,         32'h0,         1'b1, o2));

        resetn_a = 1'b0;
        resetn_b = 1'b0;
        in_a = {32'h0000_00C3, 32'h0000_0001};
        in_b = 16'h0000;
        drive_a(1'b1, 32'h0000_00A4, 32'h1111_2222);
        drive_b(1'b0, 32'h0000_00C0, 32'h0);
        tick();
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        drive_a(1'b0, 32'h0000_00C0, 32'h0);

        $display("[TB] reset then idle");
        check_output("b_out_after_reset", {48'd0, out_b}, {48'd0, 16'hA5A5});
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("idle%0d_out", i), out_a, 64'h0);
            check_output($sformatf("idle%0d_irq", i), {63'd0, irq_a}, 64'h0);
            read_a(32'h0000_00C0, 32'h0, $sformatf("idle%0d_chg", i));
            tick();
        end

        $display("[TB] register table");
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

        $display("[TB] input latency");
        in_a[31:0] = 32'h5;
        tick();
        read_a(32'h0000_0080, 32'h1, "lat_in_edge1");
        tick();
        read_a(32'h0000_0080, 32'h5, "lat_in_edge2");
        read_a(32'h0000_00C0, 32'h0, "lat_chg_edge2");
        tick();
        read_a(32'h0000_00C0, 32'h1, "lat_chg_edge3");
        check_output("lat_irq_masked", {63'd0, irq_a}, 64'h0);
        write_a(32'h0000_00C0, 32'h1);
        read_a(32'h0000_00C0, 32'h0, "lat_chg_cleared");

        $display("[TB] irq and clear");
        drive_a(1'b1, 32'h0000_00C4, 32'h1);
        in_a[31:0] = 32'h6;
        tick();
        drive_a(1'b0, 32'h0000_00C4, 32'h0);
        check_output("irq_edge1", {63'd0, irq_a}, 64'h0);
        tick();
        check_output("irq_edge2", {63'd0, irq_a}, 64'h0);
        read_a(32'h0000_00C0, 32'h0, "irq_chg_edge2");
        tick();
        read_a(32'h0000_00C0, 32'h1, "irq_chg_edge3");
        check_output("irq_edge3", {63'd0, irq_a}, 64'h1);
        write_a(32'h0000_00C0, 32'h1);
        check_output("irq_after_clear", {63'd0, irq_a}, 64'h0);
        read_a(32'h0000_00C0, 32'h0, "irq_chg_after_clear");

        in_a[63:32] = 32'h55;
        tick();
        tick();
        tick();
        read_a(32'h0000_00C0, 32'h2, "chg_bit1_set");
        check_output("irq_bit1_masked", {63'd0, irq_a}, 64'h0);
        write_a(32'h0000_00C0, 32'h2);
        read_a(32'h0000_00C0, 32'h0, "chg_bit1_cleared");

        $display("[TB] set/clear collision");
        in_a[31:0] = 32'h9;
        tick();
        tick();
        write_a(32'h0000_00C0, 32'h1);
        read_a(32'h0000_00C0, 32'h1, "collision_chg");
        check_output("collision_irq", {63'd0, irq_a}, 64'h1);
        write_a(32'h0000_00C0, 32'h0);
        read_a(32'h0000_00C0, 32'h1, "w0_keeps_chg");
        write_a(32'h0000_00C0, 32'h1);
        read_a(32'h0000_00C0, 32'h0, "final_clear_chg");
        check_output("final_clear_irq", {63'd0, irq_a}, 64'h0);

        $display("[TB] narrow width and mid-operation reset");
        read_b(32'h0000_00A0, 32'h0000_00A5, "b_out0_reset_val");
        write_b(32'h0000_00A0, 32'h0000_01FF);
        check_output("b_out_truncated", {48'd0, out_b}, {48'd0, 16'hA5FF});
        read_b(32'h0000_00A0, 32'h0000_00FF, "b_out0_readback");
        write_b(32'h0000_00C4, 32'h0000_00FF);
        read_b(32'h0000_00C4, 32'h3, "b_mask_truncated");
        in_b[7:0] = 8'h3C;
        tick();
        tick();
        tick();
        read_b(32'h0000_0080, 32'h0000_003C, "b_in0");
        read_b(32'h0000_00C0, 32'h1, "b_chg_set");
        check_output("b_irq_set", {63'd0, irq_b}, 64'h1);

        resetn_b = 1'b0;
        drive_b(1'b1, 32'h0000_00A4, 32'h0000_0077);
        check_output("b_rdata_in_reset", {32'd0, bus_b.rdata}, 64'h0);
        tick();
        resetn_b = 1'b1;
        drive_b(1'b0, 32'h0000_00C0, 32'h0);
        check_output("b_out_after_midreset", {48'd0, out_b}, {48'd0, 16'hA5A5});
        check_output("b_irq_after_midreset", {63'd0, irq_b}, 64'h0);
        read_b(32'h0000_00C4, 32'h0, "b_mask_after_midreset");
        read_b(32'h0000_00A4, 32'h0000_00A5, "b_out1_write_discarded");
        for (int i = 0; i < 5; i++) begin
            read_b(32'h0000_00C0, 32'h0, $sformatf("b_settle%0d_chg", i));
            tick();
        end
        read_b(32'h0000_0080, 32'h0000_003C, "b_in0_resynced");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
